pkt_merger4: RTL
================

Name: pkt_merger4

Overview:
- Source-side companion to the 4-port packet router: the transmitter that feeds the router's `packet_valid` / `Data_packet` input.
- Collects 16-bit payloads from four local producer ports, each port carrying its own destination tag.
- Round-robin arbitrates between ports and emits one 20-bit packet per grant, formatted as {src[1:0], dest[1:0], payload[15:0]}.
- Paces packets to the router's service rate and holds off while the downstream `Busy` is high.

Parameters:
- GAP_CYCLES, 1, idle cycles inserted after each emitted packet (0..7). Default 1 gives a 3-cycle packet period.
- CNT_W, 16, width of each per-port sent counter (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  4  per-port payload valid; bit i belongs to port i.
- in_data  input  64  per-port payload; port i on bits [16i+15:16i].
- in_dest  input  8  per-port destination; port i on bits [2i+1:2i].
- in_ready  output  4  per-port ready; equals ~hold_valid (combinational).
- busy  input  1  downstream `Busy`; sampled only in IDLE.
- packet_valid  output  1  one-cycle strobe, registered.
- Data_packet  output  20  {src, dest, payload}, registered.
- merger_idle  output  1  high when state==IDLE and no port is holding a packet.
- sent_count  output  4*CNT_W  per-port emitted-packet counters; present only with the optional feature.

Behaviour:
- Reset (async, rst=0):
  - state=IDLE, hold_valid=0, hold_data=0, hold_dest=0, last_grant=3 (so port 0 has first priority).
  - packet_valid=0, Data_packet=0, gap counter=0.
  - in_ready=4'b1111, merger_idle=1.
  - Reset mid-operation discards all held packets and any pending gap.
- Input capture, per port:
  - On a clock edge with in_valid[i] && in_ready[i], capture in_data/in_dest into that port's holding register and set hold_valid[i].
  - Each port holds at most one packet; in_ready[i] stays low until the packet is emitted.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if |hold_valid && !busy:
    - g = first set hold_valid bit searching (last_grant+1) mod 4 upward, with wrap.
    - Register Data_packet <= {g, hold_dest[g], hold_data[g]}, packet_valid <= 1, go to SEND.
    - Otherwise stay in IDLE, packet_valid=0.
  - SEND (packet_valid is high during this cycle only):
    - packet_valid <= 0.
    - Clear hold_valid[g]; in_ready[g] rises next cycle.
    - last_grant <= g.
    - If GAP_CYCLES==0 go to IDLE; else load gap counter with GAP_CYCLES and go to GAP.
  - GAP: decrement the counter; go to IDLE when it reaches 1. `busy` is ignored here.
- Data_packet holds its last value when packet_valid=0.
- Latency: payload captured at edge N → packet_valid high in the cycle after edge N+1.
- Minimum packet period is GAP_CYCLES+2 cycles.
- Simultaneous events:
  - A new in_valid on port g is not accepted in the SEND cycle, because in_ready[g] is still low.
  - Other ports may capture in any state.
- busy rising while in SEND or GAP has no effect until IDLE.

Optional Feature:
- Macro: PKT_MERGER_STATS_EN.
- Defined:
  - sent_count port exists.
  - Counter i increments in each SEND cycle where g==i, wraps modulo 2^CNT_W, and resets to 0.
- Undefined: no port, no counter logic; all other behaviour is identical.

Decomposition:
- Shared package `pkt_router_pkg`:
  - Packet field constants: SRC_MSB=19, SRC_LSB=18, DEST_MSB=17, DEST_LSB=16, PAYLOAD_W=16, PKT_W=20, NUM_PORTS=4.
  - State enum encodings.
- Sub-module `rr_arbiter4`: combinational round-robin picker. Inputs are the req[3:0] vector and last_grant[1:0]; outputs are gnt_idx[1:0] and any_req.

Test Plan:
- Port 2 sends payload 16'hBEEF, dest 3, busy=0 → packet_valid high for exactly one cycle, 2 cycles after capture; Data_packet=20'hBBEEF; in_ready[2] low until one cycle after SEND.
- All four ports valid in the same cycle, dest=port index, GAP_CYCLES=1 → packets emitted from ports 0,1,2,3 in that order, packet_valid pulses spaced exactly 3 cycles apart.
- Port 1 held, busy=1 for 10 cycles → no packet_valid and in_ready[1]=0 throughout; busy falls → packet emitted on the following cycle.
- Ports 0 and 3 streaming continuously → grants alternate 0,3,0,3; neither port is granted twice in a row.
- rst pulsed low during GAP with ports 1 and 2 held → outputs zero immediately; in_ready=4'hF; no packet after reset releases.
- PKT_MERGER_STATS_EN defined, CNT_W=2, five packets from port 0 → sent_count[1:0] reads 1 (wrapped); other counters read 0.

Source files
------------

// File: rtl/pkt_router_pkg.sv
// ---------------------------------------------------------------------------
// pkt_router_pkg
// Shared definitions for the 4-port packet router and its source-side merger.
//   - Packet field positions for the 20-bit {src, dest, payload} format.
//   - Merger FSM state encoding.
// ---------------------------------------------------------------------------
package pkt_router_pkg;

  localparam int SRC_MSB   = 19;
  localparam int SRC_LSB   = 18;
  localparam int DEST_MSB  = 17;
  localparam int DEST_LSB  = 16;
  localparam int PAYLOAD_W = 16;
  localparam int PKT_W     = 20;
  localparam int NUM_PORTS = 4;

  // Width of the post-packet idle counter (GAP_CYCLES is 0..7).
  localparam int GAP_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter4.sv
// ---------------------------------------------------------------------------
// rr_arbiter4
// Combinational round-robin picker for four requesters. The search starts
// at (last_grant_i + 1) mod 4 and wraps, so the most recently served port
// has the lowest priority.
// Ports:
//   req_i        [3:0]  request vector, bit i = requester i
//   last_grant_i [1:0]  index granted most recently
//   gnt_idx_o    [1:0]  selected requester (0 when no request)
//   any_req_o           at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] gnt_idx_o,
  output logic       any_req_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt_idx_o = 2'd0;
    found     = 1'b0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant_i + 2'(k);
      if (!found && req_i[idx]) begin
        gnt_idx_o = idx;
        found     = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/pkt_merger4.sv
// ---------------------------------------------------------------------------
// pkt_merger4
// Source-side transmitter feeding the 4-port router. Four producer ports
// each hold at most one 16-bit payload plus a 2-bit destination; a
// round-robin grant turns one held payload into a 20-bit packet
// {src, dest, payload}. After each packet the merger spends GAP_CYCLES
// idle cycles so the router is never overrun, and it only starts a new
// packet from IDLE when the downstream busy is low.
//
// Handshake: a producer transfer happens on a rising edge where
// in_valid[i] && in_ready[i]; in_ready[i] is simply "holding slot i empty".
// packet_valid is a one-cycle strobe with no backpressure; Data_packet holds
// its last value between strobes.
//
// Optional feature (macro PKT_MERGER_STATS_EN): adds sent_count, four
// CNT_W-bit wrapping counters of packets emitted per source port.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  per-port producer handshake
//   in_data            port i payload on [16i+15:16i]
//   in_dest            port i destination on [2i+1:2i]
//   busy               downstream busy, looked at only in IDLE
//   packet_valid       registered one-cycle packet strobe
//   Data_packet        registered packet {src, dest, payload}
//   merger_idle        IDLE with nothing held
//   dbg_state          current FSM state
//   sent_count         per-port packet counters (optional feature only)
// ---------------------------------------------------------------------------
module pkt_merger4
  import pkt_router_pkg::*;
#(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS*PAYLOAD_W-1:0] in_data,
  input  logic [NUM_PORTS*2-1:0]         in_dest,
  output logic [NUM_PORTS-1:0]           in_ready,
  input  logic                           busy,
  output logic                           packet_valid,
  output logic [PKT_W-1:0]               Data_packet,
  output logic                           merger_idle,
  output state_e                         dbg_state
`ifdef PKT_MERGER_STATS_EN
  ,
  output logic [NUM_PORTS*CNT_W-1:0]     sent_count
`endif
);

  state_e                                state_q, state_d;
  logic [NUM_PORTS-1:0]                  hold_valid_q, hold_valid_d;
  logic [NUM_PORTS-1:0][PAYLOAD_W-1:0]   hold_data_q, hold_data_d;
  logic [NUM_PORTS-1:0][1:0]             hold_dest_q, hold_dest_d;
  logic [1:0]                            last_grant_q, last_grant_d;
  logic [1:0]                            grant_q, grant_d;
  logic                                  pv_q, pv_d;
  logic [PKT_W-1:0]                      pkt_q, pkt_d;
  logic [GAP_W-1:0]                      gap_q, gap_d;

  logic [NUM_PORTS-1:0]                  capture;
  logic [NUM_PORTS-1:0]                  clear_mask;
  logic [1:0]                            gnt_idx;
  logic                                  any_req;
  logic                                  launch;

  rr_arbiter4 u_arb (
    .req_i        (hold_valid_q),
    .last_grant_i (last_grant_q),
    .gnt_idx_o    (gnt_idx),
    .any_req_o    (any_req)
  );

  assign in_ready     = ~hold_valid_q;
  assign capture      = in_valid & in_ready;
  assign launch       = (state_q == ST_IDLE) && any_req && !busy;
  assign packet_valid = pv_q;
  assign Data_packet  = pkt_q;
  assign merger_idle  = (state_q == ST_IDLE) && (hold_valid_q == '0);
  assign dbg_state    = state_q;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_SEND;
      ST_SEND: state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      // gap_q <= 1 also covers a counter that somehow reached 0.
      ST_GAP:  if (gap_q <= GAP_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- output / datapath next values ----------------
  always_comb begin
    pv_d         = 1'b0;
    pkt_d        = pkt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    clear_mask   = '0;
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          pv_d    = 1'b1;
          pkt_d   = {gnt_idx, hold_dest_q[gnt_idx], hold_data_q[gnt_idx]};
          grant_d = gnt_idx;
        end
      end
      ST_SEND: begin
        // Slot is freed only now, so the granted port cannot refill
        // during its own SEND cycle.
        clear_mask[grant_q] = 1'b1;
        last_grant_d        = grant_q;
        gap_d               = GAP_W'(GAP_CYCLES);
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
      end
      default: ;
    endcase
  end

  // Holding slots: clear and capture never hit the same port in one cycle
  // because capture requires the slot to already be empty.
  always_comb begin
    hold_valid_d = (hold_valid_q & ~clear_mask) | capture;
    hold_data_d  = hold_data_q;
    hold_dest_d  = hold_dest_q;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (capture[i]) begin
        hold_data_d[i] = in_data[PAYLOAD_W*i +: PAYLOAD_W];
        hold_dest_d[i] = in_dest[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      hold_dest_q  <= '0;
      last_grant_q <= 2'd3;   // port 0 wins first after reset
      grant_q      <= 2'd0;
      pv_q         <= 1'b0;
      pkt_q        <= '0;
      gap_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_dest_q  <= hold_dest_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      pv_q         <= pv_d;
      pkt_q        <= pkt_d;
      gap_q        <= gap_d;
    end
  end

`ifdef PKT_MERGER_STATS_EN
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SEND) cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign sent_count = cnt_q;
`endif

endmodule
